// File: rtl/sram_axi_bridge.sv
// Bridges the CPU inst (read-only) and data SRAM-like ports onto one AXI3 master.
// Up to one read and one write can be in flight. BRIDGE_RDATA_BUF_EN registers the R channel before it returns.
// state  | meaning
// R_IDLE | no read outstanding; data read beats inst read
// R_AR   | arvalid driven from latched request
// R_R    | rready high, waiting for rvalid
// R_WAIT | (BRIDGE_RDATA_BUF_EN) return buffered rdata
// W_IDLE | no write outstanding
// W_AW   | aw/w channels pending, each dropped after its own handshake
// W_B    | bready high, waiting for bvalid
module sram_axi_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

`ifdef BRIDGE_RDATA_BUF_EN
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R, R_WAIT} r_state_t;
`else
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
`endif
  typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

  r_state_t    r_state, r_next;
  w_state_t    w_state, w_next;
  logic        r_id;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] w_addr, w_data;
  logic [1:0]  w_size;
  logic [3:0]  w_strb;
  logic        aw_done, w_done;
  logic        data_rd_req, data_wr_req;
  logic        data_rd_grant, inst_rd_grant, data_wr_grant;
  logic        r_fire, aw_fire, w_fire;
  logic        rd_ok, rd_to_data;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid[3:1],
                         rresp, rlast, bid, bresp};

  assign data_rd_req   = data_sram_req & ~data_sram_wr;
  assign data_wr_req   = data_sram_req & data_sram_wr;
  // RAW safety: a data read waits until no write is outstanding, and vice versa.
  assign data_rd_grant = (r_state == R_IDLE) & data_rd_req & (w_state == W_IDLE);
  assign inst_rd_grant = (r_state == R_IDLE) & inst_sram_req & ~data_rd_grant;
  assign data_wr_grant = (w_state == W_IDLE) & data_wr_req & ((r_state == R_IDLE) | ~r_id);

  assign r_fire  = (r_state == R_R) & rvalid;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (data_rd_grant | inst_rd_grant) r_next = R_AR;
      R_AR:   if (arready) r_next = R_R;
`ifdef BRIDGE_RDATA_BUF_EN
      R_R:    if (rvalid) r_next = R_WAIT;
      R_WAIT: r_next = R_IDLE;
`else
      R_R:    if (rvalid) r_next = R_IDLE;
`endif
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_id    <= 1'b0;
      r_addr  <= 32'h0;
      r_size  <= 2'b0;
    end else begin
      r_state <= r_next;
      if (data_rd_grant) begin
        r_id   <= 1'b1;
        r_addr <= data_sram_addr;
        r_size <= data_sram_size;
      end else if (inst_rd_grant) begin
        r_id   <= 1'b0;
        r_addr <= inst_sram_addr;
        r_size <= inst_sram_size;
      end
    end
  end

`ifdef BRIDGE_RDATA_BUF_EN
  logic        buf_rid;
  logic [31:0] buf_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_rid   <= 1'b0;
      buf_rdata <= 32'h0;
    end else if (r_fire) begin
      buf_rid   <= rid[0];
      buf_rdata <= rdata;
    end
  end

  assign rd_ok      = (r_state == R_WAIT);
  assign rd_to_data = buf_rid;
  assign rd_data    = buf_rdata;
`else
  assign rd_ok      = r_fire;
  assign rd_to_data = rid[0];
  assign rd_data    = rdata;
`endif

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (data_wr_grant) w_next = W_AW;
      W_AW:   if ((aw_done | aw_fire) & (w_done | w_fire)) w_next = W_B;
      W_B:    if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_addr  <= 32'h0;
      w_data  <= 32'h0;
      w_size  <= 2'b0;
      w_strb  <= 4'h0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (data_wr_grant) begin
        w_addr  <= data_sram_addr;
        w_data  <= data_sram_wdata;
        w_size  <= data_sram_size;
        w_strb  <= data_sram_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (w_state == W_AW) begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
    end
  end

  assign inst_sram_addr_ok = inst_rd_grant;
  assign data_sram_addr_ok = data_rd_grant | data_wr_grant;
  assign inst_sram_data_ok = rd_ok & ~rd_to_data;
  assign data_sram_data_ok = (rd_ok & rd_to_data) | ((w_state == W_B) & bvalid);
  assign inst_sram_rdata   = rd_data;
  assign data_sram_rdata   = rd_data;

  assign arid    = {3'b0, r_id};
  assign araddr  = r_addr;
  assign arlen   = 8'h0;
  assign arsize  = {1'b0, r_size};
  assign arburst = 2'b01;
  assign arlock  = 2'b0;
  assign arcache = 4'h0;
  assign arprot  = 3'b0;
  assign arvalid = (r_state == R_AR);
  assign rready  = (r_state == R_R);

  assign awid    = 4'd1;
  assign awaddr  = w_addr;
  assign awlen   = 8'h0;
  assign awsize  = {1'b0, w_size};
  assign awburst = 2'b01;
  assign awlock  = 2'b0;
  assign awcache = 4'h0;
  assign awprot  = 3'b0;
  assign awvalid = (w_state == W_AW) & ~aw_done;
  assign wid     = 4'd1;
  assign wdata   = w_data;
  assign wstrb   = w_strb;
  assign wlast   = 1'b1;
  assign wvalid  = (w_state == W_AW) & ~w_done;
  assign bready  = (w_state == W_B);

endmodule
